// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl: WIDTH-bit add/subtract computed one nibble per cycle through a single 4-bit CLA slice,
// with valid/ready handshakes on the operand request and on the result.
module cla_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int KW = NIB > 1 ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [4:0]       c;
    logic [3:0]       sum_d;
    logic             last;

    // Select the active nibble, then resolve all slice carries in parallel from generate/propagate terms.
    always_comb begin
        a_sh  = a_q >> {k_q, 2'b00};
        b_sh  = b_q >> {k_q, 2'b00};
        g     = a_sh[3:0] & b_sh[3:0];
        p     = a_sh[3:0] ^ b_sh[3:0];
        c[0]  = c_q;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum_d = p ^ c[3:0];
        last  = k_q == KW'(NIB - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    // Subtraction is A + ~B + 1, so the inversion and the forced carry are applied at latch time.
                    a_q     <= in_a;
                    b_q     <= in_sub ? ~in_b : in_b;
                    c_q     <= in_sub | in_cin;
                    k_q     <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    for (int i = 0; i < NIB; i++)
                        if (k_q == KW'(i)) sum_q[4*i +: 4] <= sum_d;
                    c_q <= c[4];
                    k_q <= k_q + 1'b1;
                    if (last) begin
                        cout_q  <= c[4];
                        ovf_q   <= c[3] ^ c[4];
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
endmodule

// File: doc/cla_serial_add_ctrl.md
Name: cla_serial_add_ctrl

Overview:
- Sequencer that performs WIDTH-bit add/subtract by reusing one 4-bit carry-lookahead adder slice over WIDTH/4 cycles, least-significant nibble first.
- The slice carry is held in a register between nibbles.
- Operands enter through a valid/ready handshake and the result leaves through one. This gives a low-area wide adder for datapaths where throughput is not critical.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIB is derived as WIDTH/4 (not overridable). It is the number of slice passes per operation.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand request valid
- in_ready  output  1  controller can accept an operand request
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in (add mode only)
- in_sub  input  1  1 = compute A-B, 0 = compute A+B+cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of MSB (sub mode: 1 = no borrow)
- out_ovf  output  1  signed overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; nibble counter and carry register go to 0.
  - out_sum=0, out_cout=0, out_ovf=0, out_valid=0, busy=0.
  - Reset wins over every other event, including mid-RUN or mid-DONE. Any in-flight result is discarded and never presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid=1, latch the request and go to RUN with nibble counter k=0:
    - Latch A = in_a.
    - Latch B = in_sub ? ~in_b : in_b.
    - Carry register = in_sub ? 1 : in_cin. In sub mode, in_cin is ignored.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, the slice computes latched A[4k+3:4k] + B[4k+3:4k] + carry.
  - At the clk edge, the 4-bit sum is written to out_sum[4k+3:4k] and the slice carry-out to the carry register; k increments.
  - At the k=NIB-1 pass:
    - out_cout = slice carry-out.
    - out_ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), i.e. carry into slice bit 3 XOR slice carry-out.
    - Go to DONE.
  - out_sum bits not yet written keep their previous value; consumers sample only when out_valid=1.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - out_sum, out_cout and out_ovf are held stable until the handshake.
  - When out_valid&&out_ready at a clk edge, go to IDLE. out_valid drops next cycle.
  - out_sum, out_cout and out_ovf keep their last values in IDLE until the next operation overwrites them.
- Latency: request accepted at edge E0, so out_valid is first high in the cycle after edge E0+NIB (E0+4 for WIDTH=16).
- Minimum op-to-op spacing is NIB+2 cycles: 1 IDLE accept, NIB RUN, at least 1 DONE. The controller never accepts in DONE.
- Input changes on in_a/in_b/in_cin/in_sub after acceptance have no effect. in_valid while busy is ignored (in_ready=0, request not consumed).
- out_ready held high in advance is legal: DONE lasts exactly one cycle.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan (WIDTH=16):
- Add with carry ripple across nibbles: add 0x00FF+0x0001, cin=0 -> out_sum=0x0100, cout=0, ovf=0. out_valid is first high exactly 4 cycles after the accept edge, and in_ready=0 throughout busy.
- Full wrap: add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Add 0xFFFF+0x0000, cin=1 -> sum=0x0000, cout=1.
- Signed overflow: 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
- Subtract: sub 0x0005-0x0007 with in_cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored). Sub 0x0007-0x0005 -> sum=0x0002, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and out_sum stable. Toggle in_a/in_b/in_valid during RUN/DONE -> no effect on the result and no extra request accepted. Raise out_ready -> IDLE next cycle.
- Reset mid-operation: assert rst for 1 cycle at k=2 of RUN -> next cycle state IDLE, out_valid=0, out_sum=0, in_ready=1. A new request 0x1234+0x1111 then returns 0x2345.
